// File: rtl/bfm_apb2apb_cdc.sv
`timescale 1ns/1ps
// APB3-to-APB3 clock-domain-crossing bridge for BFM benches. PM-side transfers are
// replayed on the PCLK_SC bus through a 4-phase req/ack handshake.
module bfm_apb2apb_cdc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLAVES  = 16,
  parameter int SEL_LSB     = 24,
  parameter int SEL_BITS    = 4,
  parameter int TIMEOUT     = 256,
  parameter int SYNC_STAGES = 2,
  parameter int TPD         = 1
) (
  input  logic                  PCLK_PM,
  input  logic                  PRESETN_PM,
  input  logic                  PSEL_PM,
  input  logic [ADDR_WIDTH-1:0] PADDR_PM,
  input  logic                  PWRITE_PM,
  input  logic                  PENABLE_PM,
  input  logic [DATA_WIDTH-1:0] PWDATA_PM,
  output logic [DATA_WIDTH-1:0] PRDATA_PM,
  output logic                  PREADY_PM,
  output logic                  PSLVERR_PM,
  input  logic                  PCLK_SC,
  output logic [NUM_SLAVES-1:0] PSEL_SC,
  output logic [ADDR_WIDTH-1:0] PADDR_SC,
  output logic                  PWRITE_SC,
  output logic                  PENABLE_SC,
  output logic [DATA_WIDTH-1:0] PWDATA_SC,
  input  logic [DATA_WIDTH-1:0] PRDATA_SC,
  input  logic                  PREADY_SC,
  input  logic                  PSLVERR_SC
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // TPD only describes the simulation output delay; this core drives registered outputs with none.
  if (TPD < 0 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || NUM_SLAVES < 1 || NUM_SLAVES > 16 ||
      (1 << SEL_BITS) < NUM_SLAVES) begin : g_bad_cfg
    $error("bfm_apb2apb_cdc: illegal parameter combination");
  end

  typedef enum logic [1:0] {PM_IDLE, PM_WAIT_ACK, PM_WAIT_DROP} pm_state_t;
  typedef enum logic [1:0] {SC_IDLE, SC_SETUP, SC_ACCESS, SC_ACK_WAIT} sc_state_t;

  pm_state_t               pm_state_reg, pm_state_next;
  logic [ADDR_WIDTH-1:0]   hold_addr_reg, hold_addr_next;
  logic [DATA_WIDTH-1:0]   hold_wdata_reg, hold_wdata_next;
  logic                    hold_write_reg, hold_write_next;
  logic                    req_reg, req_next;
  logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
  logic                    pslverr_reg, pslverr_next;
  logic                    pready_reg, pready_next;
  logic [SYNC_STAGES-1:0]  ack_sync_reg;

  sc_state_t               sc_state_reg, sc_state_next;
  logic [SYNC_STAGES-1:0]  rst_sync_reg;
  logic [SYNC_STAGES-1:0]  req_sync_reg;
  logic                    rst_sc;
  logic [NUM_SLAVES-1:0]   psel_reg, psel_next;
  logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;
  logic                    pwrite_reg, pwrite_next;
  logic                    penable_reg, penable_next;
  logic                    ack_reg, ack_next;
  logic [DATA_WIDTH-1:0]   resp_rdata_reg, resp_rdata_next;
  logic                    resp_err_reg, resp_err_next;
  logic [TW-1:0]           tmo_cnt_reg, tmo_cnt_next;

  logic [SEL_BITS-1:0]     sel_slot;
  logic [NUM_SLAVES-1:0]   slot_hit;
  logic                    ack_s, req_s;

  assign ack_s    = ack_sync_reg[SYNC_STAGES-1];
  assign req_s    = req_sync_reg[SYNC_STAGES-1];
  assign rst_sc   = ~rst_sync_reg[SYNC_STAGES-1];
  assign sel_slot = hold_addr_reg[SEL_LSB +: SEL_BITS];

  // An unmapped slot matches no line, so an all-zero hit vector means decode error.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
    assign slot_hit[gi] = (sel_slot == SEL_BITS'(gi));
  end

  // ---------------- PM domain ----------------
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      pm_state_reg   <= PM_IDLE;
      hold_addr_reg  <= '0;
      hold_wdata_reg <= '0;
      hold_write_reg <= 1'b0;
      req_reg        <= 1'b0;
      prdata_reg     <= '0;
      pslverr_reg    <= 1'b0;
      pready_reg     <= 1'b0;
      ack_sync_reg   <= '0;
    end else begin
      pm_state_reg   <= pm_state_next;
      hold_addr_reg  <= hold_addr_next;
      hold_wdata_reg <= hold_wdata_next;
      hold_write_reg <= hold_write_next;
      req_reg        <= req_next;
      prdata_reg     <= prdata_next;
      pslverr_reg    <= pslverr_next;
      pready_reg     <= pready_next;
      ack_sync_reg   <= {ack_sync_reg[SYNC_STAGES-2:0], ack_reg};
    end
  end

  always_comb begin
    pm_state_next   = pm_state_reg;
    hold_addr_next  = hold_addr_reg;
    hold_wdata_next = hold_wdata_reg;
    hold_write_next = hold_write_reg;
    req_next        = req_reg;
    prdata_next     = prdata_reg;
    pslverr_next    = pslverr_reg;
    pready_next     = 1'b0;
    case (pm_state_reg)
      PM_IDLE: if (PSEL_PM && PENABLE_PM) begin
        hold_addr_next  = PADDR_PM;
        hold_wdata_next = PWDATA_PM;
        hold_write_next = PWRITE_PM;
        req_next        = 1'b1;
        pm_state_next   = PM_WAIT_ACK;
      end
      PM_WAIT_ACK: if (ack_s) begin
        // Response registers are static once ack has been seen through the synchroniser.
        prdata_next   = resp_rdata_reg;
        pslverr_next  = resp_err_reg;
        pready_next   = 1'b1;
        req_next      = 1'b0;
        pm_state_next = PM_WAIT_DROP;
      end
      PM_WAIT_DROP: if (!ack_s) pm_state_next = PM_IDLE;
      default: pm_state_next = PM_IDLE;
    endcase
  end

  assign PRDATA_PM  = prdata_reg;
  assign PREADY_PM  = pready_reg;
  assign PSLVERR_PM = pslverr_reg;

  // ---------------- SC domain ----------------
  always_ff @(posedge PCLK_SC or negedge PRESETN_PM) begin
    if (!PRESETN_PM) rst_sync_reg <= '0;
    else             rst_sync_reg <= {rst_sync_reg[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge PCLK_SC or posedge rst_sc) begin
    if (rst_sc) begin
      req_sync_reg   <= '0;
      sc_state_reg   <= SC_IDLE;
      psel_reg       <= '0;
      paddr_reg      <= '0;
      pwdata_reg     <= '0;
      pwrite_reg     <= 1'b0;
      penable_reg    <= 1'b0;
      ack_reg        <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      tmo_cnt_reg    <= '0;
    end else begin
      req_sync_reg   <= {req_sync_reg[SYNC_STAGES-2:0], req_reg};
      sc_state_reg   <= sc_state_next;
      psel_reg       <= psel_next;
      paddr_reg      <= paddr_next;
      pwdata_reg     <= pwdata_next;
      pwrite_reg     <= pwrite_next;
      penable_reg    <= penable_next;
      ack_reg        <= ack_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      tmo_cnt_reg    <= tmo_cnt_next;
    end
  end

  always_comb begin
    sc_state_next   = sc_state_reg;
    psel_next       = psel_reg;
    paddr_next      = paddr_reg;
    pwdata_next     = pwdata_reg;
    pwrite_next     = pwrite_reg;
    penable_next    = penable_reg;
    ack_next        = ack_reg;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    case (sc_state_reg)
      SC_IDLE: if (req_s) begin
        if (|slot_hit) begin
          psel_next     = slot_hit;
          paddr_next    = hold_addr_reg;
          pwdata_next   = hold_wdata_reg;
          pwrite_next   = hold_write_reg;
          penable_next  = 1'b0;
          sc_state_next = SC_SETUP;
        end else begin
          resp_err_next   = 1'b1;
          resp_rdata_next = '0;
          ack_next        = 1'b1;
          sc_state_next   = SC_ACK_WAIT;
        end
      end
      SC_SETUP: begin
        penable_next  = 1'b1;
        tmo_cnt_next  = '0;
        sc_state_next = SC_ACCESS;
      end
      SC_ACCESS: begin
        if (PREADY_SC || (TIMEOUT != 0 && tmo_cnt_reg == TW'(TIMEOUT - 1))) begin
          resp_rdata_next = (PREADY_SC && !pwrite_reg) ? PRDATA_SC : '0;
          resp_err_next   = PREADY_SC ? PSLVERR_SC : 1'b1;
          psel_next       = '0;
          penable_next    = 1'b0;
          paddr_next      = '0;
          pwdata_next     = '0;
          pwrite_next     = 1'b0;
          ack_next        = 1'b1;
          sc_state_next   = SC_ACK_WAIT;
        end else if (tmo_cnt_reg != {TW{1'b1}}) begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      SC_ACK_WAIT: if (!req_s) begin
        ack_next      = 1'b0;
        sc_state_next = SC_IDLE;
      end
      default: sc_state_next = SC_IDLE;
    endcase
  end

  assign PSEL_SC    = psel_reg;
  assign PADDR_SC   = paddr_reg;
  assign PWRITE_SC  = pwrite_reg;
  assign PENABLE_SC = penable_reg;
  assign PWDATA_SC  = pwdata_reg;
endmodule

// File: tb/tb_bfm_apb2apb_cdc.sv
`timescale 1ns/1ps
// Directed bench for bfm_apb2apb_cdc: vector table, randomised back-to-back traffic at
// two clock ratios, and an asynchronous reset in the middle of an SC access.
module tb_bfm_apb2apb_cdc;
  logic        PCLK_PM, PRESETN_PM, PSEL_PM, PWRITE_PM, PENABLE_PM;
  logic [31:0] PADDR_PM, PWDATA_PM, PRDATA_PM;
  logic        PREADY_PM, PSLVERR_PM;
  logic        PCLK_SC;
  logic [7:0]  PSEL_SC;
  logic [31:0] PADDR_SC, PWDATA_SC, PRDATA_SC;
  logic        PWRITE_SC, PENABLE_SC, PREADY_SC, PSLVERR_SC;

  bfm_apb2apb_cdc #(.NUM_SLAVES(8), .TIMEOUT(16)) dut (
    .PCLK_PM(PCLK_PM), .PRESETN_PM(PRESETN_PM), .PSEL_PM(PSEL_PM), .PADDR_PM(PADDR_PM),
    .PWRITE_PM(PWRITE_PM), .PENABLE_PM(PENABLE_PM), .PWDATA_PM(PWDATA_PM),
    .PRDATA_PM(PRDATA_PM), .PREADY_PM(PREADY_PM), .PSLVERR_PM(PSLVERR_PM),
    .PCLK_SC(PCLK_SC), .PSEL_SC(PSEL_SC), .PADDR_SC(PADDR_SC), .PWRITE_SC(PWRITE_SC),
    .PENABLE_SC(PENABLE_SC), .PWDATA_SC(PWDATA_SC), .PRDATA_SC(PRDATA_SC),
    .PREADY_SC(PREADY_SC), .PSLVERR_SC(PSLVERR_SC));

  real pm_half = 5.0;
  real sc_half = 18.5;
  initial begin PCLK_PM = 1'b0; forever #(pm_half) PCLK_PM = ~PCLK_PM; end
  initial begin PCLK_SC = 1'b0; forever #(sc_half) PCLK_SC = ~PCLK_SC; end

  int tests = 0;
  int failed = 0;

  // Slave model
  logic [31:0] mem [logic [31:0]];
  int slv_ws = 0;
  bit slv_err = 1'b0;
  int wcnt = 0;
  int slv_done = 0;
  initial begin PREADY_SC = 1'b0; PSLVERR_SC = 1'b0; PRDATA_SC = '0; end
  always @(negedge PCLK_SC) begin
    if (PENABLE_SC && (|PSEL_SC)) begin
      if (wcnt == slv_ws) begin
        PREADY_SC  = 1'b1;
        PSLVERR_SC = slv_err;
        if (PWRITE_SC) mem[PADDR_SC] = PWDATA_SC;
        PRDATA_SC  = (!PWRITE_SC && mem.exists(PADDR_SC)) ? mem[PADDR_SC] : 32'h0;
        slv_done++;
      end else begin
        PREADY_SC = 1'b0;
        wcnt++;
      end
    end else begin
      PREADY_SC = 1'b0; PSLVERR_SC = 1'b0; PRDATA_SC = '0; wcnt = 0;
    end
  end

  // Bus monitors (cumulative; transactions look at deltas)
  int pen_cnt = 0, psel_cnt = 0, multi_sel = 0, pready_cnt = 0;
  logic [7:0]  psel_last = '0;
  logic [31:0] paddr_last = '0;
  always @(negedge PCLK_SC) begin
    if (PENABLE_SC) pen_cnt++;
    if (|PSEL_SC) begin psel_cnt++; psel_last = PSEL_SC; paddr_last = PADDR_SC; end
    if ($countones(PSEL_SC) > 1) multi_sel++;
  end
  always @(negedge PCLK_PM) if (PREADY_PM) pready_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  int b_pen, b_psel, b_pready, b_done;
  int d_pen, d_psel, d_pready, d_done;
  logic [7:0] seen_psel;

  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output bit err);
    bit to;
    b_pen = pen_cnt; b_psel = psel_cnt; b_pready = pready_cnt; b_done = slv_done;
    rdata = '0; err = 1'b0; to = 1'b1;
    @(posedge PCLK_PM); #1;
    PSEL_PM = 1'b1; PADDR_PM = addr; PWRITE_PM = wr; PWDATA_PM = wdata; PENABLE_PM = 1'b0;
    @(posedge PCLK_PM); #1;
    PENABLE_PM = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge PCLK_PM);
      if (PREADY_PM) begin rdata = PRDATA_PM; err = PSLVERR_PM; to = 1'b0; break; end
    end
    @(posedge PCLK_PM); #1;
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0;
    check("xfer_completed", 32'(to), 32'd0);
    d_pen = pen_cnt - b_pen; d_psel = psel_cnt - b_psel;
    d_pready = pready_cnt - b_pready; d_done = slv_done - b_done;
    seen_psel = (d_psel > 0) ? psel_last : 8'h00;
    $display("[TB] %s addr=%08h wdata=%08h rdata=%08h err=%0d psel=%02h pen_cycles=%0d",
             wr ? "WR" : "RD", addr, wdata, rdata, err, seen_psel, d_pen);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ws;
    bit          slverr;
    bit          preload;
    logic [31:0] pre_data;
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [7:0]  exp_psel;
    int          exp_pen;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] rdata, addr, data;
  bit          err;
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] waddrs [$];
  int          b_pr;

  initial begin
    vecs[0] = '{1'b1, 32'h0300_0010, 32'hA5A5_1234, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h08, 1};
    vecs[1] = '{1'b0, 32'h0500_0020, 32'h0, 3, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 8'h20, 4};
    vecs[2] = '{1'b0, 32'h0C00_0000, 32'h0, 0, 1'b0, 1'b1, 32'h7777_7777, 32'h0, 1'b1, 8'h00, 0};
    vecs[3] = '{1'b0, 32'h0200_0004, 32'h0, 1000, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 8'h04, 16};
    vecs[4] = '{1'b1, 32'h0700_0008, 32'h1122_3344, 2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h80, 3};
    vecs[5] = '{1'b0, 32'h0700_0008, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h1122_3344, 1'b0, 8'h80, 1};
    vecs[6] = '{1'b1, 32'h0800_0000, 32'hFFFF_0000, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'h00, 0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0, 1, 1'b0, 1'b1, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 8'h01, 2};

    PSEL_PM = 1'b0; PENABLE_PM = 1'b0; PWRITE_PM = 1'b0; PADDR_PM = '0; PWDATA_PM = '0;
    PRESETN_PM = 1'b1;
    #2 PRESETN_PM = 1'b0;
    repeat (3) @(posedge PCLK_SC);
    #1;
    check("rst_psel_sc", 32'(PSEL_SC), 32'h0);
    check("rst_penable_sc", 32'(PENABLE_SC), 32'h0);
    check("rst_paddr_sc", PADDR_SC, 32'h0);
    check("rst_pwrite_sc", 32'(PWRITE_SC), 32'h0);
    check("rst_pready_pm", 32'(PREADY_PM), 32'h0);
    check("rst_prdata_pm", PRDATA_PM, 32'h0);
    check("rst_pslverr_pm", 32'(PSLVERR_PM), 32'h0);
    @(posedge PCLK_PM); #1 PRESETN_PM = 1'b1;
    repeat (6) @(posedge PCLK_SC);

    for (int i = 0; i < 8; i++) begin
      slv_ws = vecs[i].ws; slv_err = vecs[i].slverr;
      if (vecs[i].preload) mem[vecs[i].addr] = vecs[i].pre_data;
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, err);
      check($sformatf("v%0d_prdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_psel", i), 32'(seen_psel), 32'(vecs[i].exp_psel));
      check($sformatf("v%0d_penable_cycles", i), 32'(d_pen), 32'(vecs[i].exp_pen));
      check($sformatf("v%0d_psel_cycles", i), 32'(d_psel),
            (vecs[i].exp_pen > 0) ? 32'(vecs[i].exp_pen + 1) : 32'd0);
      check($sformatf("v%0d_pready_pulses", i), 32'(d_pready), 32'd1);
      if (vecs[i].exp_psel != 8'h00) check($sformatf("v%0d_paddr_sc", i), paddr_last, vecs[i].addr);
    end
    slv_err = 1'b0;

    // Back-to-back alternating traffic at 1:3 and then 3:1 clock ratios
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin pm_half = 5.0;  sc_half = 15.0; end
      else        begin pm_half = 15.0; sc_half = 5.0;  end
      repeat (3) @(posedge PCLK_PM);
      for (int i = 0; i < 10; i++) begin
        addr = {4'h0, 4'($urandom_range(0, 7)), 16'h0, 4'($urandom_range(0, 15)), 4'h0};
        data = $urandom;
        slv_ws = $urandom_range(0, 2);
        apb_xfer(1'b1, addr, data, rdata, err);
        exp_mem[addr] = data;
        waddrs.push_back(addr);
        check("rnd_wr_err", 32'(err), 32'h0);
        check("rnd_wr_pready", 32'(d_pready), 32'd1);
        check("rnd_wr_slave_once", 32'(d_done), 32'd1);
        check("rnd_wr_psel", 32'(seen_psel), 32'(8'h01 << addr[26:24]));
        addr = waddrs[$urandom_range(0, waddrs.size() - 1)];
        slv_ws = $urandom_range(0, 2);
        apb_xfer(1'b0, addr, 32'h0, rdata, err);
        check("rnd_rd_data", rdata, exp_mem[addr]);
        check("rnd_rd_err", 32'(err), 32'h0);
        check("rnd_rd_pready", 32'(d_pready), 32'd1);
        check("rnd_rd_slave_once", 32'(d_done), 32'd1);
      end
    end
    check("psel_onehot", 32'(multi_sel), 32'd0);

    // Reset while the SC side sits in ACCESS with a stalled slave
    slv_ws = 1000;
    b_pr = pready_cnt;
    @(posedge PCLK_PM); #1;
    PSEL_PM = 1'b1; PADDR_PM = 32'h0100_0040; PWRITE_PM = 1'b1; PWDATA_PM = 32'h0BAD_0BAD;
    PENABLE_PM = 1'b0;
    @(posedge PCLK_PM); #1 PENABLE_PM = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge PCLK_SC);
      if (PENABLE_SC) break;
    end
    check("rst_mid_access_reached", 32'(PENABLE_SC), 32'h1);
    #2 PRESETN_PM = 1'b0;
    #1;
    check("rst_mid_psel_async", 32'(PSEL_SC), 32'h0);
    check("rst_mid_penable_async", 32'(PENABLE_SC), 32'h0);
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0;
    repeat (5) @(posedge PCLK_PM);
    #1 PRESETN_PM = 1'b1;
    repeat (10) @(posedge PCLK_SC);
    check("rst_mid_no_pready", 32'(pready_cnt - b_pr), 32'd0);
    slv_ws = 0;
    apb_xfer(1'b1, 32'h0100_0040, 32'h5A5A_0F0F, rdata, err);
    check("post_rst_wr_err", 32'(err), 32'h0);
    check("post_rst_wr_pready", 32'(d_pready), 32'd1);
    check("post_rst_slave_mem", mem[32'h0100_0040], 32'h5A5A_0F0F);
    apb_xfer(1'b0, 32'h0100_0040, 32'h0, rdata, err);
    check("post_rst_rd_data", rdata, 32'h5A5A_0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
